sram64x16_arb: RTL

Two-port arbiter and sequencer for the 64-word x 16-bit single-port SRAM wrapper `mem_64_16_gf180` in the riscv32i_3d cache. After reset it clears all 64 words to zero. It then shares the single macro port between two requesters (port 0: fetch/refill, port 1: data/store) using round-robin arbitration. All macro command pins are driven from flops, and read data is returned with a fixed latency.

---
 rtl/sram64x16_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/sram64x16_arb.sv
// Round-robin two-port arbiter and command sequencer for the 64x16 single-port SRAM macro.
// Zero-fills the array after reset (optional), then registers one macro command per cycle.
module sram64x16_arb #(
  parameter int AW         = 6,
  parameter int DW         = 16,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_gnt,
  output logic          p1_gnt,
  output logic          p0_rvalid,
  output logic          p1_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_idat,
  input  logic [DW-1:0] mem_odat,
  output logic          init_done
);

  localparam int STAGES = 2;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic vld;
    logic port;
  } rd_tag_t;

  state_t                  state;
  logic [AW-1:0]           cnt;
  logic                    last;   // 1 = port 1 was granted most recently
  rd_tag_t [STAGES:1]      vld_pipe;
  req_t                    sel;
  rd_tag_t                 rd_in;
  logic                    run;
  logic                    accept;

  assign run    = (state == S_RUN);
  assign p0_gnt = run & p0_req & (~p1_req | last);
  assign p1_gnt = run & p1_req & (~p0_req | ~last);
  assign accept = p0_gnt | p1_gnt;

  assign sel = p1_gnt ? req_t'{p1_we, p1_addr, p1_wdata}
                      : req_t'{p0_we, p0_addr, p0_wdata};

  assign rd_in.vld  = accept & ~sel.we;
  assign rd_in.port = p1_gnt;

  // Data comes back from the macro one cycle after it samples the command,
  // so the tag sits one stage behind the registered command.
  assign p0_rvalid = vld_pipe[STAGES].vld & ~vld_pipe[STAGES].port;
  assign p1_rvalid = vld_pipe[STAGES].vld &  vld_pipe[STAGES].port;
  assign p0_rdata  = mem_odat;
  assign p1_rdata  = mem_odat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_CLEAR ? S_INIT : S_RUN;
      cnt       <= '0;
      last      <= 1'b1;
      mem_ce    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_idat  <= '0;
      init_done <= ~INIT_CLEAR;
      vld_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_in;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
      case (state)
        S_INIT: begin
          mem_ce   <= 1'b0;
          mem_we   <= 1'b1;
          mem_addr <= cnt;
          mem_idat <= '0;
          cnt      <= cnt + 1'b1;
          if (&cnt) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            mem_ce   <= 1'b0;
            mem_we   <= sel.we;
            mem_addr <= sel.addr;
            if (sel.we) mem_idat <= sel.wdata;
            last     <= p1_gnt;
          end else begin
            mem_ce <= 1'b1;
            mem_we <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
